// File: rtl/nanoboot_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : nanoboot_program_loader
// Description : Pulls a program image byte-by-byte from the nanofs multiblock
//               reader, packs it little-endian into 32-bit words and writes
//               the words into the boot program RAM. Reports done, overflow
//               or reader timeout to the boot sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module nanoboot_program_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int MAX_WORDS      = 4096,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  output logic                  done,
  output logic [1:0]            err,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  fs_start,
  output logic                  fs_req_byte,
  input  logic                  fs_busy,
  input  logic                  fs_eof,
  input  logic [7:0]            fs_byte,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be
);

  localparam int                    c_to_width   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0]   c_max_words  = (ADDR_WIDTH + 1)'(MAX_WORDS);
  localparam logic [c_to_width-1:0] c_to_last    = c_to_width'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]            c_err_none   = 2'd0;
  localparam logic [1:0]            c_err_ovf    = 2'd1;
  localparam logic [1:0]            c_err_tmo    = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_START      = 4'd1,
    S_WAIT_AVAIL = 4'd2,
    S_CAPTURE    = 4'd3,
    S_REQ        = 4'd4,
    S_WAIT_ACK   = 4'd5,
    S_WRITE      = 4'd6,
    S_FLUSH      = 4'd7,
    S_DONE       = 4'd8,
    S_ERROR      = 4'd9
  } state_t;

  state_t                  r_state;
  logic [1:0]              r_lane;
  logic [31:0]             r_shift;
  logic [c_to_width-1:0]   r_to_cnt;

  logic                    w_full;
  logic [3:0]              w_flush_be;
  logic [ADDR_WIDTH:0]     w_count_inc;

  // RAM is full once word_count reaches the image capacity; a partial word
  // only enables the lanes already filled.
  assign w_full      = (word_count == c_max_words);
  assign w_flush_be  = (4'd1 << r_lane) - 4'd1;
  assign w_count_inc = word_count + (ADDR_WIDTH + 1)'(1);

  // Loader FSM with registered strobes: every strobe is raised on the
  // transition into the state that owns it and dropped on the way out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lane      <= 2'd0;
      r_shift     <= 32'd0;
      r_to_cnt    <= '0;
      done        <= 1'b0;
      err         <= c_err_none;
      word_count  <= '0;
      fs_start    <= 1'b0;
      fs_req_byte <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 32'd0;
      mem_be      <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          // Load is honoured only here; a restart clears all progress.
          if (load) begin
            r_lane     <= 2'd0;
            r_shift    <= 32'd0;
            r_to_cnt   <= '0;
            word_count <= '0;
            done       <= 1'b0;
            err        <= c_err_none;
            fs_start   <= 1'b1;
            r_state    <= S_START;
          end
        end

        S_START: begin
          fs_start <= 1'b0;
          r_state  <= S_WAIT_AVAIL;
        end

        S_WAIT_AVAIL: begin
          if (!fs_busy) begin
            r_to_cnt <= '0;
            if (fs_eof) begin
              // Queue the partial-word write so it is on the bus during FLUSH.
              if ((r_lane != 2'd0) && !w_full) begin
                mem_we    <= 1'b1;
                mem_addr  <= word_count[ADDR_WIDTH-1:0];
                mem_wdata <= r_shift;
                mem_be    <= w_flush_be;
              end
              r_state <= S_FLUSH;
            end else begin
              r_state <= S_CAPTURE;
            end
          end else if (r_to_cnt == c_to_last) begin
            r_to_cnt <= '0;
            err      <= c_err_tmo;
            r_state  <= S_ERROR;
          end else begin
            r_to_cnt <= r_to_cnt + c_to_width'(1);
          end
        end

        S_CAPTURE: begin
          r_shift[8*r_lane +: 8] <= fs_byte;
          r_lane                 <= r_lane + 2'd1;
          if (r_lane == 2'd3) begin
            // Fourth byte completes the word; write it next cycle unless full.
            if (!w_full) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_count[ADDR_WIDTH-1:0];
              mem_wdata <= {fs_byte, r_shift[23:0]};
              mem_be    <= 4'hF;
            end
            r_state <= S_WRITE;
          end else begin
            fs_req_byte <= 1'b1;
            r_state     <= S_REQ;
          end
        end

        S_WRITE: begin
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= 32'd0;
          mem_be    <= 4'd0;
          if (w_full) begin
            err     <= c_err_ovf;
            r_state <= S_ERROR;
          end else begin
            word_count  <= w_count_inc;
            r_lane      <= 2'd0;
            r_shift     <= 32'd0;
            fs_req_byte <= 1'b1;
            r_state     <= S_REQ;
          end
        end

        S_REQ: begin
          fs_req_byte <= 1'b0;
          r_state     <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          // Wait for the reader to go busy so the old byte is not resampled.
          if (fs_busy) begin
            if (r_to_cnt == c_to_last) begin
              r_to_cnt <= '0;
              err      <= c_err_tmo;
              r_state  <= S_ERROR;
            end else begin
              r_to_cnt <= r_to_cnt + c_to_width'(1);
              r_state  <= S_WAIT_AVAIL;
            end
          end else begin
            r_to_cnt <= '0;
          end
        end

        S_FLUSH: begin
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= 32'd0;
          mem_be    <= 4'd0;
          if ((r_lane != 2'd0) && w_full) begin
            err     <= c_err_ovf;
            r_state <= S_ERROR;
          end else begin
            if (r_lane != 2'd0) begin
              word_count <= w_count_inc;
            end
            r_lane  <= 2'd0;
            r_shift <= 32'd0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nanoboot_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_nanoboot_program_loader
// Description : Self-checking bench for nanoboot_program_loader with a
//               behavioural nanofs reader and a RAM-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nanoboot_program_loader;

  localparam int AW = 4;
  localparam int MAXW = 2;
  localparam int TMO = 50;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic          done;
  logic [1:0]    err;
  logic [AW:0]   word_count;
  logic          fs_start;
  logic          fs_req_byte;
  logic          fs_busy;
  logic          fs_eof;
  logic [7:0]    fs_byte;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_writes = 0;
  wr_t  sb[$];

  // Reader model controls
  logic [7:0] rd_img[$];
  int         rd_hold  = 0;
  bit         rd_stuck = 1'b0;

  always #5 clk = ~clk;

  nanoboot_program_loader #(
    .ADDR_WIDTH(AW),
    .MAX_WORDS(MAXW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .done(done),
    .err(err),
    .word_count(word_count),
    .fs_start(fs_start),
    .fs_req_byte(fs_req_byte),
    .fs_busy(fs_busy),
    .fs_eof(fs_eof),
    .fs_byte(fs_byte),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural reader: busy for two cycles after start/req, then presents
  // the next byte (or EOF) with busy low.
  initial begin
    int phase;
    int cnt;
    int idx;
    phase = 0; cnt = 0; idx = 0;
    fs_busy = 1'b0; fs_eof = 1'b0; fs_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        phase = 0; fs_busy = 1'b0; fs_eof = 1'b0; fs_byte = 8'h00;
      end else if (rd_stuck) begin
        fs_busy = 1'b1;
      end else if (fs_start) begin
        idx = 0; phase = 1; cnt = 2; fs_busy = 1'b1; fs_eof = 1'b0;
      end else if (phase == 1) begin
        cnt--;
        if (cnt == 0) begin
          fs_busy = 1'b0;
          if (idx < rd_img.size()) begin
            fs_eof = 1'b0; fs_byte = rd_img[idx];
          end else begin
            fs_eof = 1'b1; fs_byte = 8'h00;
          end
          phase = 2;
        end
      end else if (phase == 2) begin
        if (fs_req_byte) begin
          idx++;
          if (rd_hold > 0) begin
            cnt = rd_hold; phase = 3;
          end else begin
            fs_busy = 1'b1; cnt = 2; phase = 1;
          end
        end
      end else if (phase == 3) begin
        cnt--;
        if (cnt == 0) begin
          fs_busy = 1'b1; cnt = 2; phase = 1;
        end
      end
    end
  end

  // Write monitor: every RAM strobe must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        n_writes++;
        if (sb.size() == 0) begin
          check_eq("unexpected_write", {mem_addr, mem_wdata, mem_be}, 64'h0);
        end else begin
          e = sb.pop_front();
          check_eq("wr_addr", 64'(mem_addr), 64'(e.addr));
          check_eq("wr_data", 64'(mem_wdata), 64'(e.data));
          check_eq("wr_be", 64'(mem_be), 64'(e.be));
        end
      end
    end
  end

  // Push expected writes for the current image; returns word count and err.
  task automatic expect_image(output int exp_wc, output int exp_err);
    int nw;
    wr_t w;
    nw = (rd_img.size() + 3) / 4;
    for (int i = 0; i < nw && i < MAXW; i++) begin
      w.addr = AW'(i);
      w.data = 32'd0;
      w.be   = 4'd0;
      for (int b = 0; b < 4; b++) begin
        if (i * 4 + b < rd_img.size()) begin
          w.data[8*b +: 8] = rd_img[i*4 + b];
          w.be[b] = 1'b1;
        end
      end
      sb.push_back(w);
    end
    exp_wc  = (nw > MAXW) ? MAXW : nw;
    exp_err = (nw > MAXW) ? 1 : 0;
  endtask

  task automatic pulse_load();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic wait_end(input string tag, output int cycles);
    cycles = 1;
    while (!(done || err != 2'd0) && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    if (!(done || err != 2'd0)) check_eq({tag, "_wait_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_image(input string tag, input int hold, input bit extra_load);
    int ewc, eerr, cyc;
    rd_hold = hold;
    expect_image(ewc, eerr);
    pulse_load();
    if (extra_load) begin
      repeat (8) @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
    end
    wait_end(tag, cyc);
    repeat (3) @(negedge clk);
    check_eq({tag, "_done"}, 64'(done), (eerr == 0) ? 64'd1 : 64'd0);
    check_eq({tag, "_err"}, 64'(err), 64'(eerr));
    check_eq({tag, "_wc"}, 64'(word_count), 64'(ewc));
    check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    int cyc;
    int wbase;
    reset = 1'b1;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", {done, err, fs_start, fs_req_byte, mem_we, mem_be},
             64'd0);
    check_eq("rst_wc", 64'(word_count), 64'd0);
    check_eq("rst_bus", {mem_addr, mem_wdata}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Two full words, with a stray load mid-run that must be ignored.
    rd_img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_image("full8", 0, 1'b1);

    // One full word plus a two-byte partial word.
    rd_img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_image("part6", 0, 1'b0);

    // Three-byte partial only.
    rd_img = '{8'h5A, 8'h6B, 8'h7C};
    run_image("part3", 0, 1'b0);

    // Immediate EOF.
    rd_img.delete();
    wbase = n_writes;
    run_image("empty", 0, 1'b0);
    check_eq("empty_nowrite", 64'(n_writes - wbase), 64'd0);

    // Reader holds busy low after each request: bytes must not be resampled.
    rd_img = '{8'h10, 8'h20, 8'h30, 8'h40};
    wbase = n_writes;
    run_image("hold3", 3, 1'b0);
    check_eq("hold3_nwrites", 64'(n_writes - wbase), 64'd1);

    // Overflow: third word suppressed.
    rd_img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h09, 8'h0A, 8'h0B, 8'h0C};
    wbase = n_writes;
    run_image("ovf12", 0, 1'b0);
    check_eq("ovf12_nwrites", 64'(n_writes - wbase), 64'd2);

    // Timeout with the reader stuck busy.
    rd_stuck = 1'b1;
    wbase = n_writes;
    pulse_load();
    wait_end("tmo", cyc);
    check_eq("tmo_err", 64'(err), 64'd2);
    check_eq("tmo_latency_ok", 64'((cyc >= TMO) && (cyc <= TMO + 4)), 64'd1);
    check_eq("tmo_nowrite", 64'(n_writes - wbase), 64'd0);
    check_eq("tmo_done", 64'(done), 64'd0);
    rd_stuck = 1'b0;
    @(negedge clk);

    // Reset mid-stream, then a fresh load must restart at address 0.
    rd_img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    expect_image(cyc, cyc);
    wbase = n_writes;
    pulse_load();
    cyc = 0;
    while (n_writes == wbase && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rstmid_first_write", 64'(n_writes - wbase), 64'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rstmid_outs", {done, err, fs_start, fs_req_byte, mem_we, word_count},
             64'd0);
    reset = 1'b0;
    sb.delete();
    rd_img = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_image("rstmid_reload", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
